hack_alu_seq: RTL and testbench
===============================

# hack_alu_seq

Parametrised, handshaked successor to the Hack combinational ALU. It applies the Hack control encoding (zx, nx, zy, ny, f, no) to WIDTH-bit operands and registers the result and flags. It adds an overflow flag and an optional iterative multiply mode. It sits between the CPU operand/decode stage and writeback, and decouples them with valid/ready on both sides.

## Interface
- WIDTH, 16: operand/result width in bits; must be ≥ 2.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and controls valid.
- in_ready  out  1  block accepts operation this cycle.
- x, y  in  WIDTH  operands.
- zx, nx, zy, ny, f, no  in  1 each  Hack ALU control bits.
- mul  in  1  select multiply instead of f-stage; ignored without HACK_ALU_MUL_EN.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream consumes result this cycle.
- out  out  WIDTH  result.
- zr, ng, ov  out  1 each  out==0; out[WIDTH-1]; signed add overflow.

## Operation
- Pre-stage: x1 = (zx ? 0 : x) ^ {WIDTH{nx}}; y1 likewise with zy/ny.
- f-stage: f=1 → x1+y1 mod 2^WIDTH; f=0 → x1&y1. mul=1 (when compiled in) → low WIDTH bits of x1*y1, unsigned shift-add; f ignored.
- Post-stage: out = r ^ {WIDTH{no}}; zr, ng computed from final out.
- ov = 1 only when f=1, mul=0, and x1, y1 share sign bit differing from the sum's sign bit (before no). ov=0 for AND and multiply.
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- States: IDLE, MUL, FULL.
  - IDLE: in_ready=1. Accept with mul=0 → result registered, go FULL. Accept with mul=1 → latch x1, y1, no; clear accumulator and bit counter; go MUL.
  - MUL: one multiplier bit (LSB first) per cycle. After WIDTH iterations, register result and flags, go FULL. in_ready=0.
  - FULL: out_valid=1. in_ready = out_ready, so back-to-back non-multiply ops sustain one per cycle. On out transfer: accept in same edge → behave as IDLE acceptance; no accept → IDLE.
- out, zr, ng, ov stable while out_valid=1 and out_ready=0.
- Inputs sampled only at acceptance; later changes to x, y, or controls do not affect an operation in flight.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, out=0, zr=0, ng=0, ov=0, accumulator and counter 0.
- Reset mid-MUL or in FULL: operation/result discarded; no out transfer reported.
- Non-multiply latency: accepted at edge N → out_valid=1 after edge N+1... more precisely, visible from edge N (registered at acceptance edge), consumable at edge N+1 at earliest.
- Multiply latency: accepted at edge N → out_valid visible after edge N+WIDTH; in_ready low for cycles following edges N..N+WIDTH-1.
- in_ready depends combinationally on out_ready only in FULL; no other comb path input→output.
- Counter is ceil(log2(WIDTH+1)) bits; no wrap within one operation.

## Configuration
- HACK_ALU_MUL_EN defined: mul input honoured, MUL state, accumulator, and counter built.
- Undefined: mul ignored (treated 0), no MUL state or multiplier registers. Every accepted op completes in one cycle; otherwise identical.

## Test plan
- WIDTH=16, x=5, y=3, f=1, others 0, out_ready=1 → out=8, zr=0, ng=0, ov=0; out_valid from edge after acceptance.
- x=0x7FFF, y=0x0001, f=1 → out=0x8000, ng=1, ov=1. zx=zy=f=1 → out=0, zr=1. zx=nx=zy=ny=f=no=1 → out=1.
- Back-to-back: 4 non-multiply ops on consecutive cycles with out_ready=1 → 4 results on 4 consecutive cycles, in_ready held 1.
- Backpressure: out_ready=0 for 3 cycles after result 0x0008 → out held 0x0008, in_ready=0; then out_ready=1 → transfer, next op accepted same edge.
- Multiply (HACK_ALU_MUL_EN): x=7, y=6, mul=1 → in_ready=0 for 16 cycles, then out=42, ov=0. x=0xFFFF, y=0xFFFF → out=0x0001.
- Reset at 8th MUL cycle → next cycle out_valid=0, in_ready=1, out=0; no stale result appears.

Source files
------------

// File: rtl/hack_alu_seq_if.sv
// hack_alu_seq_if: operand/control request and result/flag response bus for hack_alu_seq
interface hack_alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;
    logic             mul;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             ov;

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
        input  in_ready, out_valid, out, zr, ng, ov
    );

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
        output in_ready, out_valid, out, zr, ng, ov
    );
endinterface

// File: rtl/hack_alu_seq.sv
// hack_alu_seq: registered, handshaked Hack ALU with overflow flag; shift-add multiply built only when HACK_ALU_MUL_EN is defined
module hack_alu_seq #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           reset,
    hack_alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef HACK_ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, FULL} state_t;
`else
    typedef enum logic [1:0] {IDLE, FULL} state_t;
`endif

    state_t           state;
    state_t           state_nx;
    state_t           go_state;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] r;
    logic             ov_c;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             load_ov;
    logic [WIDTH-1:0] out_q;
    logic             zr_q;
    logic             ng_q;
    logic             ov_q;

`ifdef HACK_ALU_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic [CW-1:0]    cnt;
    logic             no_l;
    logic             mul_done;
`else
    logic             unused_mul;
    logic [CW-1:0]    unused_cw;
    assign unused_mul = bus.mul;
    assign unused_cw  = '0;
`endif

    // Hack pre-stage, f-stage and signed-add overflow on the live operands
    always_comb begin
        x1   = (bus.zx ? '0 : bus.x) ^ {WIDTH{bus.nx}};
        y1   = (bus.zy ? '0 : bus.y) ^ {WIDTH{bus.ny}};
        sum  = x1 + y1;
        r    = bus.f ? sum : (x1 & y1);
        ov_c = bus.f & (x1[WIDTH-1] == y1[WIDTH-1]) & (sum[WIDTH-1] != x1[WIDTH-1]);
    end

    // Acceptance and where an accepted op goes; multiply only when compiled in
    always_comb begin
        accept = bus.in_valid & bus.in_ready;
`ifdef HACK_ALU_MUL_EN
        go_state = bus.mul ? MUL : FULL;
`else
        go_state = FULL;
`endif
    end

`ifdef HACK_ALU_MUL_EN
    // One multiplier bit per cycle, LSB first; last iteration feeds the result register
    always_comb begin
        acc_nx   = acc + (mplier[0] ? mcand : '0);
        mul_done = (state == MUL) && (cnt == CW'(WIDTH - 1));
    end

    // Multiplier operands latched at acceptance so later input changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            no_l   <= 1'b0;
        end else if (accept && bus.mul) begin
            mcand  <= x1;
            mplier <= y1;
            acc    <= '0;
            cnt    <= '0;
            no_l   <= bus.no;
        end else if (state == MUL) begin
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            acc    <= acc_nx;
            cnt    <= cnt + CW'(1);
        end
    end

    // Result load: single-cycle op at acceptance, or multiply completion
    always_comb begin
        load     = (accept & ~bus.mul) | mul_done;
        load_val = mul_done ? (acc_nx ^ {WIDTH{no_l}}) : (r ^ {WIDTH{bus.no}});
        load_ov  = ~mul_done & ov_c;
    end
`else
    // Result load: every accepted op completes at its acceptance edge
    always_comb begin
        load     = accept;
        load_val = r ^ {WIDTH{bus.no}};
        load_ov  = ov_c;
    end
`endif

    // Result and flags held until the next load so they stay stable under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else if (load) begin
            out_q <= load_val;
            zr_q  <= (load_val == '0);
            ng_q  <= load_val[WIDTH-1];
            ov_q  <= load_ov;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: accept wins, else drain FULL on transfer, else finish multiply
    always_comb begin
        state_nx = state;
        if (accept) state_nx = go_state;
        else if (state == FULL && bus.out_ready) state_nx = IDLE;
`ifdef HACK_ALU_MUL_EN
        else if (mul_done) state_nx = FULL;
`endif
    end

    // Handshake outputs; in_ready follows out_ready only while holding a result
    always_comb begin
        bus.in_ready  = (state == IDLE) | ((state == FULL) & bus.out_ready);
        bus.out_valid = (state == FULL);
        bus.out       = out_q;
        bus.zr        = zr_q;
        bus.ng        = ng_q;
        bus.ov        = ov_q;
    end
endmodule

// File: tb/tb_hack_alu_seq.sv
// tb_hack_alu_seq: directed checks of hack_alu_seq arithmetic, flags, handshake, backpressure and reset
module tb_hack_alu_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    hack_alu_seq_if #(.WIDTH(W)) bus ();

    hack_alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // c = {zx, nx, zy, ny, f, no}
    task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] c);
        bus.x = a;
        bus.y = b;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = c;
        bus.mul = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] o, input logic z, input logic n, input logic v);
        chk({tag, ".valid"}, W'(bus.out_valid), W'(1'b1));
        chk({tag, ".out"}, bus.out, o);
        chk({tag, ".zr"}, W'(bus.zr), W'(z));
        chk({tag, ".ng"}, W'(bus.ng), W'(n));
        chk({tag, ".ov"}, W'(bus.ov), W'(v));
    endtask

    // Single op with out_ready=1: result visible after acceptance edge, consumed on the next
    task automatic one_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] c,
                          input logic [W-1:0] o, input logic z, input logic n, input logic v);
        set_op(a, b, c);
        bus.in_valid = 1'b1;
        chk({tag, ".in_ready"}, W'(bus.in_ready), W'(1'b1));
        tick();
        bus.in_valid = 1'b0;
        chk_res(tag, o, z, n, v);
        tick();
        chk({tag, ".drained"}, W'(bus.out_valid), W'(1'b0));
    endtask

    logic [W-1:0] bb_a [4] = '{16'd1, 16'd2, 16'd3, 16'h00FF};
    logic [W-1:0] bb_b [4] = '{16'd1, 16'd2, 16'd3, 16'h0F0F};
    logic [5:0]   bb_c [4] = '{6'b000010, 6'b000010, 6'b000010, 6'b000000};
    logic [W-1:0] bb_e [4] = '{16'd2, 16'd4, 16'd6, 16'h000F};

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_op('0, '0, 6'b0);
        tick();
        tick();
        chk("rst.in_ready", W'(bus.in_ready), W'(1'b1));
        chk("rst.out_valid", W'(bus.out_valid), W'(1'b0));
        chk("rst.out", bus.out, '0);
        chk("rst.zr", W'(bus.zr), W'(1'b0));
        chk("rst.ng", W'(bus.ng), W'(1'b0));
        chk("rst.ov", W'(bus.ov), W'(1'b0));
        reset = 1'b0;
        bus.out_ready = 1'b1;

        one_op("add5p3",   16'd5,    16'd3,    6'b000010, 16'd8,    1'b0, 1'b0, 1'b0);
        one_op("addovf",   16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1, 1'b1);
        one_op("zero",     16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0, 1'b0);
        one_op("one",      16'h1234, 16'h5678, 6'b111111, 16'h0001, 1'b0, 1'b0, 1'b0);
        one_op("and",      16'hF0F0, 16'hFF00, 6'b000000, 16'hF000, 1'b0, 1'b1, 1'b0);
        one_op("negovf",   16'h8000, 16'h8000, 6'b000010, 16'h0000, 1'b1, 1'b0, 1'b1);
        one_op("ov_pre_no",16'h7FFF, 16'h0001, 6'b000011, 16'h7FFF, 1'b0, 1'b0, 1'b1);

        set_op(16'h0010, 16'h0020, 6'b000010);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.x = 16'h1234;
        bus.y = 16'hFFFF;
        bus.f = 1'b0;
        #1;
        chk("inflight.out", bus.out, 16'h0030);
        tick();
        chk("inflight.drained", W'(bus.out_valid), W'(1'b0));

        for (int i = 0; i < 4; i++) begin
            set_op(bb_a[i], bb_b[i], bb_c[i]);
            bus.in_valid = 1'b1;
            chk($sformatf("b2b%0d.in_ready", i), W'(bus.in_ready), W'(1'b1));
            tick();
            chk($sformatf("b2b%0d.valid", i), W'(bus.out_valid), W'(1'b1));
            chk($sformatf("b2b%0d.out", i), bus.out, bb_e[i]);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("b2b.drained", W'(bus.out_valid), W'(1'b0));

        bus.out_ready = 1'b0;
        set_op(16'd5, 16'd3, 6'b000010);
        bus.in_valid = 1'b1;
        tick();
        set_op(16'd10, 16'd20, 6'b000010);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d.valid", i), W'(bus.out_valid), W'(1'b1));
            chk($sformatf("bp%0d.out", i), bus.out, 16'h0008);
            chk($sformatf("bp%0d.in_ready", i), W'(bus.in_ready), W'(1'b0));
            tick();
        end
        chk("bp.held", bus.out, 16'h0008);
        bus.out_ready = 1'b1;
        #1;
        chk("bp.in_ready", W'(bus.in_ready), W'(1'b1));
        tick();
        chk_res("bp.next", 16'd30, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("bp.drained", W'(bus.out_valid), W'(1'b0));

        bus.out_ready = 1'b0;
        set_op(16'h7FFF, 16'h0001, 6'b000010);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("rstfull.pre", bus.out, 16'h8000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstfull.valid", W'(bus.out_valid), W'(1'b0));
        chk("rstfull.in_ready", W'(bus.in_ready), W'(1'b1));
        chk("rstfull.out", bus.out, '0);
        chk("rstfull.ng", W'(bus.ng), W'(1'b0));
        chk("rstfull.ov", W'(bus.ov), W'(1'b0));
        bus.out_ready = 1'b1;
        tick();
        chk("rstfull.after", W'(bus.out_valid), W'(1'b0));

`ifdef HACK_ALU_MUL_EN
        set_op(16'd7, 16'd6, 6'b000010);
        bus.mul = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.mul = 1'b0;
        bus.x = 16'd0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mul%0d.in_ready", i), W'(bus.in_ready), W'(1'b0));
            chk($sformatf("mul%0d.valid", i), W'(bus.out_valid), W'(1'b0));
            tick();
        end
        chk_res("mul7x6", 16'd42, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mul7x6.drained", W'(bus.out_valid), W'(1'b0));

        set_op(16'hFFFF, 16'hFFFF, 6'b000000);
        bus.mul = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.mul = 1'b0;
        repeat (16) tick();
        chk_res("mulffff", 16'h0001, 1'b0, 1'b0, 1'b0);
        tick();

        set_op(16'd7, 16'd6, 6'b000000);
        bus.mul = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.mul = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmul.valid", W'(bus.out_valid), W'(1'b0));
        chk("rstmul.in_ready", W'(bus.in_ready), W'(1'b1));
        chk("rstmul.out", bus.out, '0);
        repeat (12) tick();
        chk("rstmul.nostale", W'(bus.out_valid), W'(1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
